// File: rtl/fp_align_stage1.sv
// fp_align_stage1: two-stage pre-alignment pipeline for the FP add/sub path.
//   Stage A unpacks X/Y, resolves exponent difference flags, mantissa compare,
//   effective operation and swaps operands by magnitude.
//   Stage B right-shifts the smaller significand into {sig, G, R, S}.
// Ports:
//   Clk, Reset (sync, active high)
//   InValid/InReady, OperandX/OperandY, Operation : input handshake + operands
//   OutValid/OutReady                               : output handshake
//   SignOperandX/Y, EffOperation, ExclusiveSign,
//   DSign, DZF, CMP1, LargeExp, LargeMant, SmallMant : aligned results
module fp_align_stage1 #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [EXP_W+MAN_W:0]     OperandX,
  input  logic [EXP_W+MAN_W:0]     OperandY,
  input  logic [1:0]               Operation,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic                     SignOperandX,
  output logic                     SignOperandY,
  output logic                     EffOperation,
  output logic                     ExclusiveSign,
  output logic                     DSign,
  output logic                     DZF,
  output logic                     CMP1,
  output logic [EXP_W-1:0]         LargeExp,
  output logic [MAN_W+3:0]         LargeMant,
  output logic [MAN_W+3:0]         SmallMant
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;   // significand incl. hidden bit
  localparam int MW = MAN_W + 4;   // significand + G/R/S

  typedef struct packed {
    logic             sx, sy, eff, excl, dsign, dzf, cmp1;
    logic [EXP_W-1:0] exp_l;
    logic [SW-1:0]    sig_l, sig_s;
    logic [EXP_W:0]   shamt;
  } stage_a_t;

  typedef struct packed {
    logic             sx, sy, eff, excl, dsign, dzf, cmp1;
    logic [EXP_W-1:0] exp_l;
    logic [MW-1:0]    mant_l, mant_s;
  } stage_b_t;

  logic     va_q, vb_q;
  stage_a_t a_d, a_q;
  stage_b_t b_d, b_q;

  // Stage B may take new data when empty or draining this cycle.
  logic adv_b, acc_in;
  assign adv_b   = ~vb_q | OutReady;
  assign InReady = ~va_q | ~vb_q | OutReady;
  assign acc_in  = InValid & InReady;

  // ---------------- Stage A: unpack, compare, swap ----------------
  logic [EXP_W-1:0] ex_x, ex_y, eex_x, eex_y;
  logic [SW-1:0]    sig_x, sig_y;
  logic [EXP_W:0]   diff;
  logic             sel_y;

  always_comb begin
    ex_x  = OperandX[W-2:MAN_W];
    ex_y  = OperandY[W-2:MAN_W];
    // Denormals use effective exponent 1 with a zero hidden bit.
    eex_x = (ex_x == '0) ? EXP_W'(1) : ex_x;
    eex_y = (ex_y == '0) ? EXP_W'(1) : ex_y;
    sig_x = {ex_x != '0, OperandX[MAN_W-1:0]};
    sig_y = {ex_y != '0, OperandY[MAN_W-1:0]};
    diff  = {1'b0, eex_x} - {1'b0, eex_y};

    a_d       = '0;
    a_d.sx    = OperandX[W-1];
    a_d.sy    = OperandY[W-1];
    a_d.excl  = a_d.sx ^ a_d.sy;
    a_d.eff   = ~Operation[1] & (Operation[0] ^ a_d.sx ^ a_d.sy);
    a_d.dsign = ~diff[EXP_W];
    a_d.dzf   = (diff == '0);
    a_d.cmp1  = (sig_y > sig_x);
    sel_y     = ~a_d.dsign | (a_d.dzf & a_d.cmp1);
    a_d.exp_l = sel_y ? eex_y : eex_x;
    a_d.sig_l = sel_y ? sig_y : sig_x;
    a_d.sig_s = sel_y ? sig_x : sig_y;
    a_d.shamt = diff[EXP_W] ? (~diff + 1'b1) : diff;
  end

  // ---------------- Stage B: align smaller significand ----------------
  logic [2*MW-1:0] shifted;
  logic            sticky;

  always_comb begin
    // Upper half is the aligned value, lower half catches bits shifted out.
    shifted = {a_q.sig_s, 3'b000, {MW{1'b0}}} >> a_q.shamt;
    sticky  = |shifted[MW-1:0];

    b_d        = '0;
    b_d.sx     = a_q.sx;
    b_d.sy     = a_q.sy;
    b_d.eff    = a_q.eff;
    b_d.excl   = a_q.excl;
    b_d.dsign  = a_q.dsign;
    b_d.dzf    = a_q.dzf;
    b_d.cmp1   = a_q.cmp1;
    b_d.exp_l  = a_q.exp_l;
    b_d.mant_l = {a_q.sig_l, 3'b000};
    if (a_q.shamt >= (EXP_W+1)'(MW))
      b_d.mant_s = {{(MW-1){1'b0}}, a_q.sig_s != '0};
    else
      b_d.mant_s = {shifted[2*MW-1:MW+1], shifted[MW] | sticky};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      if (InReady) va_q <= InValid;
      if (acc_in)  a_q  <= a_d;
      if (adv_b) begin
        vb_q <= va_q;
        if (va_q) b_q <= b_d;
      end
    end
  end

  assign OutValid      = vb_q;
  assign SignOperandX  = b_q.sx;
  assign SignOperandY  = b_q.sy;
  assign EffOperation  = b_q.eff;
  assign ExclusiveSign = b_q.excl;
  assign DSign         = b_q.dsign;
  assign DZF           = b_q.dzf;
  assign CMP1          = b_q.cmp1;
  assign LargeExp      = b_q.exp_l;
  assign LargeMant     = b_q.mant_l;
  assign SmallMant     = b_q.mant_s;
endmodule

// File: tb/tb_fp_align_stage1.sv
module tb_fp_align_stage1;
  localparam int EW = 8;
  localparam int MN = 23;
  localparam int W  = 1 + EW + MN;

  logic          Clk = 1'b0;
  logic          Reset, InValid, InReady, OutValid, OutReady;
  logic [W-1:0]  OperandX, OperandY;
  logic [1:0]    Operation;
  logic          SignOperandX, SignOperandY, EffOperation, ExclusiveSign;
  logic          DSign, DZF, CMP1;
  logic [EW-1:0] LargeExp;
  logic [MN+3:0] LargeMant, SmallMant;

  int total = 0;
  int bad   = 0;

  // Packed view of all result fields for compact compares.
  logic [68:0] obs;
  assign obs = {SignOperandX, SignOperandY, EffOperation, ExclusiveSign,
                DSign, DZF, CMP1, LargeExp, LargeMant, SmallMant};

  logic [68:0] q[$];

  fp_align_stage1 #(.EXP_W(EW), .MAN_W(MN)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .OperandX(OperandX), .OperandY(OperandY), .Operation(Operation),
    .OutValid(OutValid), .OutReady(OutReady),
    .SignOperandX(SignOperandX), .SignOperandY(SignOperandY),
    .EffOperation(EffOperation), .ExclusiveSign(ExclusiveSign),
    .DSign(DSign), .DZF(DZF), .CMP1(CMP1), .LargeExp(LargeExp),
    .LargeMant(LargeMant), .SmallMant(SmallMant)
  );

  always #5 Clk = ~Clk;

  // Reference: plain integer arithmetic on the unpacked fields.
  function automatic logic [68:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op);
    int ex, ey, d, sh;
    longint sgx, sgy, sl, ss, v, sm;
    bit sx, sy, eff, ysel;
    sx  = x[31];
    sy  = y[31];
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    sgx = longint'(x[22:0]) + ((ex != 0) ? (longint'(1) << 23) : 0);
    sgy = longint'(y[22:0]) + ((ey != 0) ? (longint'(1) << 23) : 0);
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    d    = ex - ey;
    sh   = (d < 0) ? -d : d;
    ysel = (d < 0) || (d == 0 && sgy > sgx);
    sl   = ysel ? sgy : sgx;
    ss   = ysel ? sgx : sgy;
    if (sh >= 27) sm = (ss != 0) ? 1 : 0;
    else begin
      v  = ss * 8;
      sm = v >> sh;
      if ((v % (longint'(1) << sh)) != 0) sm = sm | 1;
    end
    eff = op[1] ? 1'b0 : (op[0] ^ sx ^ sy);
    return {sx, sy, eff, sx ^ sy, d >= 0, d == 0, sgy > sgx,
            8'(ysel ? ey : ex), 27'(sl * 8), 27'(sm)};
  endfunction

  task automatic drive_one(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    @(negedge Clk);
    InValid = 1'b1; OperandX = x; OperandY = y; Operation = op;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0; OperandX = $urandom; OperandY = $urandom;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b1; OutReady = 1'b1;
    OperandX = 32'h3F800000; OperandY = 32'h40000000; Operation = 2'b00;
    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b want=0", OutValid); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL reset_inready got=%b want=1", InReady); end
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", obs); end
    Reset = 1'b0; InValid = 1'b0;
    repeat (2) @(negedge Clk); #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_nooutput got=%b want=0", OutValid); end
  endtask

  task automatic test_equal_exp();
    drive_one(32'h3FC00000, 32'h3F800000, 2'b00);
    #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", OutValid); end
    @(negedge Clk); #1;
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL equal_valid got=%b want=1", OutValid); end
    total++;
    if (obs !== {7'b0000110, 8'd127, 27'h6000000, 27'h4000000}) begin
      bad++; $display("FAIL equal_exp got=%h want=%h", obs, {7'b0000110, 8'd127, 27'h6000000, 27'h4000000});
    end
  endtask

  task automatic test_swap();
    drive_one(32'h3F800000, 32'h40000000, 2'b01);
    @(negedge Clk); #1;
    total++;
    if (OutValid !== 1'b1 || obs !== {7'b0010000, 8'd128, 27'h4000000, 27'h2000000}) begin
      bad++; $display("FAIL swap got=%b/%h want=1/%h", OutValid, obs, {7'b0010000, 8'd128, 27'h4000000, 27'h2000000});
    end
  endtask

  task automatic test_saturate();
    drive_one(32'h4E800000, 32'h3F800000, 2'b00);
    @(negedge Clk); #1;
    total++;
    if (obs !== {7'b0000100, 8'd157, 27'h4000000, 27'h0000001}) begin
      bad++; $display("FAIL sat_shift30 got=%h want=%h", obs, {7'b0000100, 8'd157, 27'h4000000, 27'h0000001});
    end
    drive_one(32'h4B800000, 32'h3F800000, 2'b00);
    @(negedge Clk); #1;
    total++;
    if (obs !== {7'b0000100, 8'd151, 27'h4000000, 27'h0000004}) begin
      bad++; $display("FAIL sat_shift24 got=%h want=%h", obs, {7'b0000100, 8'd151, 27'h4000000, 27'h0000004});
    end
  endtask

  task automatic test_sign_mix();
    drive_one(32'hBF800000, 32'h3F800000, 2'b00);
    @(negedge Clk); #1;
    total++;
    if (obs !== {7'b1011110, 8'd127, 27'h4000000, 27'h4000000}) begin
      bad++; $display("FAIL sign_mix got=%h want=%h", obs, {7'b1011110, 8'd127, 27'h4000000, 27'h4000000});
    end
    drive_one(32'hBF800000, 32'h3F800000, 2'b10);
    @(negedge Clk); #1;
    total++;
    if (EffOperation !== 1'b0) begin bad++; $display("FAIL mul_effop got=%b want=0", EffOperation); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, hold = 0;
    bit seen = 0, stall_seen = 0, prev_stall = 0;
    logic [68:0] prev_obs = '0, e;
    logic [31:0] x, y;
    q.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (OutValid) seen = 1;
      OutReady = !(seen && hold < 3);
      if (seen && hold < 3) hold++;
      InValid = (sent < 4);
      x = $urandom; y = $urandom; y[30:23] = x[30:23] - 8'(c);
      OperandX = x; OperandY = y; Operation = 2'(c);
      #1;
      if (prev_stall) begin
        total++;
        if (OutValid !== 1'b1 || obs !== prev_obs) begin
          bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", OutValid, obs, prev_obs);
        end
      end
      if (!InReady) stall_seen = 1;
      if (OutValid && OutReady) begin
        got++; total++;
        e = (q.size() != 0) ? q.pop_front() : '1;
        if (obs !== e) begin bad++; $display("FAIL bp_order got=%h want=%h", obs, e); end
      end
      prev_stall = OutValid && !OutReady;
      prev_obs   = obs;
      if (InValid && InReady) begin q.push_back(model(x, y, Operation)); sent++; end
      @(posedge Clk);
    end
    @(negedge Clk);
    InValid = 1'b0; OutReady = 1'b1;
    total++; if (got !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got); end
    total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL bp_inready_drop got=%b want=1", stall_seen); end
  endtask

  task automatic test_reset_midflight();
    logic [68:0] e;
    OutReady = 1'b1;
    @(negedge Clk);
    InValid = 1'b1; OperandX = 32'h3F800000; OperandY = 32'h40400000; Operation = 2'b00;
    @(negedge Clk);
    OperandX = 32'h40A00000;
    @(negedge Clk);
    Reset = 1'b1; InValid = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; InValid = 1'b0;
    #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_mid_outvalid got=%b want=0", OutValid); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL rst_mid_inready got=%b want=1", InReady); end
    @(negedge Clk); #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_mid_flushed got=%b want=0", OutValid); end
    e = model(32'hC1200000, 32'h3E000000, 2'b01);
    drive_one(32'hC1200000, 32'h3E000000, 2'b01);
    #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_fresh_early got=%b want=0", OutValid); end
    @(negedge Clk); #1;
    total++;
    if (OutValid !== 1'b1 || obs !== e) begin
      bad++; $display("FAIL rst_fresh got=%b/%h want=1/%h", OutValid, obs, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, r;
    logic [68:0] e;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      OutReady = ($urandom % 4) != 0;
      InValid  = ($urandom % 3) != 0;
      x = $urandom; y = $urandom; r = $urandom;
      if (r[0]) y[30:23] = x[30:23] + 8'(r[7:3]) - 8'd16;
      if (r[10:8] == 3'd0) x[30:23] = 8'd0;
      if (r[13:11] == 3'd0) y[30:23] = 8'd0;
      OperandX = x; OperandY = y; Operation = r[17:16];
      #1;
      if (OutValid && OutReady) begin
        total++;
        e = (q.size() != 0) ? q.pop_front() : '1;
        if (obs !== e) begin bad++; $display("FAIL rand_result got=%h want=%h", obs, e); end
      end
      if (InValid && InReady) q.push_back(model(x, y, Operation));
      @(posedge Clk);
    end
    @(negedge Clk);
    InValid = 1'b0; OutReady = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      #1;
      if (OutValid) begin
        total++;
        e = q.pop_front();
        if (obs !== e) begin bad++; $display("FAIL rand_drain got=%h want=%h", obs, e); end
      end
      @(negedge Clk);
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_equal_exp();
    test_swap();
    test_saturate();
    test_sign_mix();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_align_stage1.md
Name: fp_align_stage1

Overview:
- Pre-alignment pipeline for the add/sub path. Feeds the sign-resolution stage (SignStage2) and the mantissa adder.
- Unpacks two IEEE-754-format operands and computes exponent difference flags, mantissa compare, effective operation and exclusive sign.
- Swaps the operands by magnitude and right-shifts the smaller mantissa, producing guard/round/sticky bits.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Operand width W = 1+EXP_W+MAN_W.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operand pair valid.
- InReady  output  1  stage can accept an operand pair this cycle.
- OperandX  input  W  first operand.
- OperandY  input  W  second operand.
- Operation  input  2  00 add, 01 sub, 10 mul, 11 div.
- OutValid  output  1  outputs valid.
- OutReady  input  1  downstream accepts this cycle.
- SignOperandX  output  1  sign of X.
- SignOperandY  output  1  sign of Y.
- EffOperation  output  1  1 = effective subtraction.
- ExclusiveSign  output  1  SignX ^ SignY.
- DSign  output  1  1 when Ex >= Ey.
- DZF  output  1  1 when Ex == Ey.
- CMP1  output  1  1 when My > Mx (significands incl. hidden bit).
- LargeExp  output  EXP_W  effective exponent of larger-exponent operand.
- LargeMant  output  MAN_W+4  {hidden, fraction, 3'b000}.
- SmallMant  output  MAN_W+4  aligned {hidden, fraction, G, R, S}.

Behaviour:
- Unpack:
  - Hidden bit = (exp != 0).
  - Effective exponent = exp, or 1 when exp == 0 (denormal).
  - Significand = {hidden, fraction}, MAN_W+1 bits.
- Stage A (registered at end of cycle 1):
  - Compute D = EffEx - EffEy (EXP_W+1 bits, signed) and the flags:
    - DSign = ~D[EXP_W].
    - DZF = (D == 0).
    - CMP1 = (SigY > SigX), unsigned.
    - ExclusiveSign = Sx ^ Sy.
    - EffOperation = Operation[0] ^ Sx ^ Sy for add/sub; for mul/div EffOperation = 0.
  - Select the larger operand: Y when ~DSign, or when DZF & CMP1; otherwise X.
  - Register the shift amount |D|.
- Stage B (registered at end of cycle 2):
  - LargeMant = {SigLarge, 3'b000}.
  - SmallMant = {SigSmall, 3'b000} >> shift, where bit 0 = sticky = OR of all bits shifted out at or below position 0.
  - Shift >= MAN_W+4 saturates: SmallMant = {0..0, S}, with S = 1 if SigSmall != 0.
  - Equal exponents: shift 0, SmallMant = {SigSmall, 000}.
  - All flag and sign fields ride alongside unchanged.
- Latency: 2 cycles from InValid&InReady to OutValid, when unstalled. Throughput: 1 per cycle.
- Handshake:
  - Transfer occurs on a side when valid & ready are both high.
  - Stage B holds when OutValid & ~OutReady; all outputs stay stable until accepted.
  - Stage A advances when stage B is empty or draining.
  - InReady = ~VA | ~VB | OutReady. It is combinational from OutReady; there is no combinational path from InValid.
  - Inputs sampled only on acceptance; OperandX/Y may change freely otherwise.
  - Simultaneous accept-in and drain-out in a full pipe: both occur; no bubble, no loss.
- Reset:
  - VA, VB, OutValid = 0; all data/flag registers = 0; InReady = 1 during the following cycle.
  - Reset mid-operation discards in-flight operations; no OutValid is produced for them.
  - Reset dominates concurrent InValid.

Test Plan:
- Equal exponents: X=0x3FC00000, Y=0x3F800000, op=00 -> after 2 cycles DZF=1, DSign=1, CMP1=0, EffOperation=0, LargeMant=0x6000000, SmallMant=0x4000000.
- Swap: X=0x3F800000, Y=0x40000000, op=01 -> DSign=0, DZF=0, CMP1=0, EffOperation=1, LargeExp=128, SmallMant=0x2000000 (shift 1).
- Saturated shift: X=0x4E800000 (exp 157), Y=0x3F800000 (exp 127) -> shift 30, SmallMant=0x0000001 (sticky only), LargeExp=157. A second case with diff 24 -> SmallMant=0x0000004 (guard only).
- Sign mix: X=0xBF800000, Y=0x3F800000, op=00 -> ExclusiveSign=1, EffOperation=1, SignOperandX=1, SignOperandY=0.
- Backpressure: stream 4 back-to-back ops with OutReady=0 for 3 cycles after the first OutValid -> InReady drops once both stages are full. Outputs hold stable; all 4 results emerge in order with no drop or duplication.
- Reset mid-flight: assert Reset one cycle after accepting 2 ops -> OutValid stays 0 and InReady=1 in the next cycle. A fresh op then yields its result exactly 2 cycles later.
